upp_rx_deframer: RTL and testbench
==================================

# upp_rx_deframer

Receive side of the uPP link (DSP → FPGA) in the BLVDS/uPP bridge: samples 16-bit uPP words, validates framing (sync word, length, 16-bit additive checksum), buffers each payload in an 18-bit FIFO and releases it to the BLVDS transmit path only after the checksum passes. Bad frames are rolled back and never reach the BLVDS side. Runs on the 70 MHz uPP clock domain; the BLVDS transmitter reads through a valid/ready port.

## Interface
- SYNC_WORD, 16'hF5F5, first word of every frame
- MAX_LEN, 255, largest legal payload length in words (1..MAX_LEN)
- FIFO_AW, 9, FIFO address width; 2**FIFO_AW entries, must be ≥ MAX_LEN
- iCLK  in  1  single clock (70 MHz uPP domain); all logic on posedge
- iRESET  in  1  synchronous, active-high reset
- iUPP_START  in  1  uPP START, marks first word of a line; valid only with iUPP_ENA
- iUPP_ENA  in  1  uPP ENABLE; iUPP_DATA sampled when high
- iUPP_DATA  in  16  uPP data word
- iTX_READY  in  1  BLVDS transmitter accepts oTX_DATA this cycle
- oTX_DATA  out  18  {tag[1:0], payload[15:0]}; tag 2'b10 first, 2'b00 middle, 2'b01 last, 2'b11 single-word frame
- oTX_VALID  out  1  oTX_DATA holds a committed word
- oFRAME_OK  out  1  1-cycle pulse: frame committed
- oERR_SYNC, oERR_LEN, oERR_CSUM, oERR_OVF  out  1 each  1-cycle error pulses
- oBUSY  out  1  FSM not in IDLE

## Operation
- Frame on uPP: SYNC_WORD, LEN, LEN payload words, CSUM = payload sum mod 2^16. Only cycles with iUPP_ENA=1 count.
- FSM IDLE → LEN → PAYLOAD → CSUM → IDLE.
- IDLE: word with START=1: equals SYNC_WORD → LEN; otherwise oERR_SYNC, stay. Words with START=0 ignored.
- LEN: LEN=0 or >MAX_LEN → oERR_LEN, IDLE. LEN > free entries (2**FIFO_AW minus entries between read pointer and speculative write pointer) → oERR_OVF, IDLE, nothing written. Else latch LEN, clear sum and word counter → PAYLOAD.
- PAYLOAD: each word written at speculative write pointer with its tag (computed from counter and LEN), added to sum; after word LEN → CSUM.
- CSUM: match → committed pointer := speculative pointer, oFRAME_OK; mismatch → speculative pointer := committed pointer, oERR_CSUM. Either way → IDLE.
- START=1 in LEN/PAYLOAD/CSUM: current frame rolled back, oERR_LEN, word treated as in IDLE (resync on same cycle if SYNC_WORD).
- Read side: first-word-fall-through output register; reads only up to committed pointer. Transfer when oTX_VALID & iTX_READY; oTX_DATA stable while oTX_VALID=1 and iTX_READY=0.
- Pointers FIFO_AW+1 bits wide (wrap bit for full/empty); sum and counter wrap naturally (16 bits).
- Simultaneous read and commit/rollback in one cycle both take effect; rollback never touches committed data.

## Timing
- Reset: FSM IDLE, all pointers 0, oTX_VALID=0, oTX_DATA=0, all pulses 0, oBUSY=0; uncommitted frame discarded.
- CSUM word sampled at edge k: oFRAME_OK/oERR_CSUM high cycle after edge k; pointer updated at edge k.
- Empty buffer: first word of committed frame has oTX_VALID=1 after edge k+1 (latency 2 edges from CSUM).
- Sustained throughput 1 word/cycle each side; ENA gaps of any length allowed mid-frame.
- Error pulses exactly 1 cycle, at most one error per sampled word.

## Structure
- Shared package upp_blvds_pkg: tag encodings, FSM state enum, default SYNC_WORD.
- One sub-module: upp_rx_fifo (simple dual-port RAM, 18 bits × 2**FIFO_AW, registered read), inferable to M9K.
- FSM, checksum, pointer/commit logic and FWFT register in upp_rx_deframer.

## Test plan
- Frame F5F5, 0003, 0001, 0002, 0003, 0006; iTX_READY=1 → oFRAME_OK; outputs 2_0001, 0_0002, 1_0003 (tag_data), then oTX_VALID=0.
- Same frame with CSUM 0007 → oERR_CSUM, no oTX_VALID; following good 1-word frame F5F5, 0001, ABCD, ABCD → single output 3_ABCD.
- LEN=0 and LEN=256 → oERR_LEN each, nothing written; first word 1234 with START → oERR_SYNC.
- START+F5F5 arriving after 2 payload words of a LEN=5 frame → oERR_LEN, old words dropped, new frame commits and outputs correctly.
- iTX_READY=0, FIFO_AW=4: commit 10-word frame, then LEN=8 → oERR_OVF; release ready → exactly the 10 words, stable while stalled.
- iRESET asserted mid-PAYLOAD with committed data pending → all outputs at reset values next cycle, no words emitted after.

Source files
------------

// File: rtl/upp_blvds_pkg.sv
// Shared definitions for the uPP/BLVDS bridge: word tags, receive FSM states
// and the default frame sync word.
package upp_blvds_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hF5F5;

    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_LAST   = 2'b01;
    localparam logic [1:0] TAG_FIRST  = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } rx_state_t;

    function automatic logic [1:0] word_tag(input logic first, input logic last);
        logic [1:0] tag;
        case ({first, last})
            2'b11:   tag = TAG_SINGLE;
            2'b10:   tag = TAG_FIRST;
            2'b01:   tag = TAG_LAST;
            default: tag = TAG_MID;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/upp_rx_fifo.sv
// Simple dual-port buffer RAM with registered read port; no reset on the
// array or read register so it maps onto block RAM.
module upp_rx_fifo #(
    parameter int unsigned DW = 18,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/upp_rx_deframer.sv
// uPP receive deframer: checks sync/length/checksum, buffers payload
// speculatively and exposes only committed frames on a valid/ready port.
module upp_rx_deframer
    import upp_blvds_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int unsigned MAX_LEN   = 255,
    parameter int unsigned FIFO_AW   = 9
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iUPP_START,
    input  logic        iUPP_ENA,
    input  logic [15:0] iUPP_DATA,
    input  logic        iTX_READY,
    output logic [17:0] oTX_DATA,
    output logic        oTX_VALID,
    output logic        oFRAME_OK,
    output logic        oERR_SYNC,
    output logic        oERR_LEN,
    output logic        oERR_CSUM,
    output logic        oERR_OVF,
    output logic        oBUSY
);

    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    rx_state_t state, state_nxt;

    logic [PW-1:0] wr_spec, wr_commit, rd_ptr;
    logic [PW-1:0] used, free;
    logic [15:0]   len, cnt, sum;
    logic [17:0]   wr_data, ram_q;

    logic wr_en, start_frame, commit, rollback;
    logic ok_nxt, err_sync_nxt, err_len_nxt, err_csum_nxt, err_ovf_nxt;
    logic fetch, tx_valid;

    // Space is measured against the speculative pointer so an in-flight frame counts.
    assign used    = wr_spec - rd_ptr;
    assign free    = PW'(DEPTH) - used;
    assign wr_data = {word_tag(cnt == 16'd0, cnt == len - 16'd1), iUPP_DATA};

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_en        = 1'b0;
        start_frame  = 1'b0;
        commit       = 1'b0;
        rollback     = 1'b0;
        ok_nxt       = 1'b0;
        err_sync_nxt = 1'b0;
        err_len_nxt  = 1'b0;
        err_csum_nxt = 1'b0;
        err_ovf_nxt  = 1'b0;
        if (iUPP_ENA) begin
            if (iUPP_START && state != ST_IDLE) begin
                // Abort reports as a length error only; the same word may resync.
                rollback    = 1'b1;
                err_len_nxt = 1'b1;
                state_nxt   = (iUPP_DATA == SYNC_WORD) ? ST_LEN : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (iUPP_START) begin
                            if (iUPP_DATA == SYNC_WORD) begin
                                state_nxt = ST_LEN;
                            end else begin
                                err_sync_nxt = 1'b1;
                            end
                        end
                    end
                    ST_LEN: begin
                        state_nxt = ST_IDLE;
                        if (iUPP_DATA == 16'd0 || 32'(iUPP_DATA) > MAX_LEN) begin
                            err_len_nxt = 1'b1;
                        end else if (32'(iUPP_DATA) > 32'(free)) begin
                            err_ovf_nxt = 1'b1;
                        end else begin
                            start_frame = 1'b1;
                            state_nxt   = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        wr_en = 1'b1;
                        if (cnt == len - 16'd1) begin
                            state_nxt = ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        state_nxt = ST_IDLE;
                        if (iUPP_DATA == sum) begin
                            commit = 1'b1;
                            ok_nxt = 1'b1;
                        end else begin
                            rollback     = 1'b1;
                            err_csum_nxt = 1'b1;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            len       <= '0;
            cnt       <= '0;
            sum       <= '0;
            wr_spec   <= '0;
            wr_commit <= '0;
            oFRAME_OK <= 1'b0;
            oERR_SYNC <= 1'b0;
            oERR_LEN  <= 1'b0;
            oERR_CSUM <= 1'b0;
            oERR_OVF  <= 1'b0;
        end else begin
            oFRAME_OK <= ok_nxt;
            oERR_SYNC <= err_sync_nxt;
            oERR_LEN  <= err_len_nxt;
            oERR_CSUM <= err_csum_nxt;
            oERR_OVF  <= err_ovf_nxt;
            if (start_frame) begin
                len <= iUPP_DATA;
                cnt <= '0;
                sum <= '0;
            end else if (wr_en) begin
                cnt <= cnt + 16'd1;
                sum <= sum + iUPP_DATA;
            end
            if (rollback) begin
                wr_spec <= wr_commit;
            end else if (wr_en) begin
                wr_spec <= wr_spec + PW'(1);
            end
            if (commit) begin
                wr_commit <= wr_spec;
            end
        end
    end

    // The RAM read register doubles as the FWFT output register.
    assign fetch = (wr_commit != rd_ptr) && (!tx_valid || iTX_READY);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            rd_ptr   <= '0;
            tx_valid <= 1'b0;
        end else if (fetch) begin
            rd_ptr   <= rd_ptr + PW'(1);
            tx_valid <= 1'b1;
        end else if (iTX_READY) begin
            tx_valid <= 1'b0;
        end
    end

    upp_rx_fifo #(
        .DW(18),
        .AW(FIFO_AW)
    ) u_fifo (
        .clk     (iCLK),
        .wr_en   (wr_en),
        .wr_addr (wr_spec[FIFO_AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (fetch),
        .rd_addr (rd_ptr[FIFO_AW-1:0]),
        .rd_data (ram_q)
    );

    assign oTX_VALID = tx_valid;
    assign oTX_DATA  = tx_valid ? ram_q : '0;
    assign oBUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_upp_rx_deframer.sv
// Scoreboard bench for upp_rx_deframer: stimulus pushes expected words and
// pulse counts; a negedge monitor pops and compares.
module tb_upp_rx_deframer;

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iUPP_START = 1'b0;
    logic        iUPP_ENA = 1'b0;
    logic [15:0] iUPP_DATA = '0;
    logic        iTX_READY = 1'b1;
    logic [17:0] oTX_DATA;
    logic        oTX_VALID, oFRAME_OK, oERR_SYNC, oERR_LEN, oERR_CSUM, oERR_OVF, oBUSY;

    int total = 0;
    int bad = 0;

    logic [17:0] exp_q[$];
    int n_ok = 0, n_sync = 0, n_len = 0, n_csum = 0, n_ovf = 0;
    int e_ok = 0, e_sync = 0, e_len = 0, e_csum = 0, e_ovf = 0;
    logic        stall_prev = 1'b0;
    logic [17:0] prev_data = '0;

    upp_rx_deframer #(
        .SYNC_WORD (16'hF5F5),
        .MAX_LEN   (15),
        .FIFO_AW   (4)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iUPP_START (iUPP_START),
        .iUPP_ENA   (iUPP_ENA),
        .iUPP_DATA  (iUPP_DATA),
        .iTX_READY  (iTX_READY),
        .oTX_DATA   (oTX_DATA),
        .oTX_VALID  (oTX_VALID),
        .oFRAME_OK  (oFRAME_OK),
        .oERR_SYNC  (oERR_SYNC),
        .oERR_LEN   (oERR_LEN),
        .oERR_CSUM  (oERR_CSUM),
        .oERR_OVF   (oERR_OVF),
        .oBUSY      (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge iCLK) begin
        if (iRESET) begin
            stall_prev = 1'b0;
        end else begin
            if (oFRAME_OK) n_ok++;
            if (oERR_SYNC) n_sync++;
            if (oERR_LEN)  n_len++;
            if (oERR_CSUM) n_csum++;
            if (oERR_OVF)  n_ovf++;
            if (stall_prev) begin
                chk("stall_hold", {13'd0, oTX_VALID, oTX_DATA}, {13'd0, 1'b1, prev_data});
            end
            if (oTX_VALID && iTX_READY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {14'd0, oTX_DATA}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_data", {14'd0, oTX_DATA}, {14'd0, exp_q.pop_front()});
                end
            end
            stall_prev = oTX_VALID && !iTX_READY;
            prev_data  = oTX_DATA;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic word(input logic s, input logic [15:0] d);
        iUPP_ENA = 1'b1; iUPP_START = s; iUPP_DATA = d;
        @(posedge iCLK); #1;
        iUPP_ENA = 1'b0; iUPP_START = 1'b0; iUPP_DATA = '0;
    endtask

    // ENA low with START/SYNC present: must be ignored entirely.
    task automatic gap(input int n);
        iUPP_ENA = 1'b0; iUPP_START = 1'b1; iUPP_DATA = 16'hF5F5;
        cycles(n);
        iUPP_START = 1'b0; iUPP_DATA = '0;
    endtask

    task automatic check_counts(input string tag);
        cycles(4);
        chk({tag, ":ok"},   n_ok,   e_ok);
        chk({tag, ":sync"}, n_sync, e_sync);
        chk({tag, ":len"},  n_len,  e_len);
        chk({tag, ":csum"}, n_csum, e_csum);
        chk({tag, ":ovf"},  n_ovf,  e_ovf);
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            if (toggle) iTX_READY = i[0];
            cycles(1);
        end
        iTX_READY = 1'b1;
        cycles(3);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        cycles(3);
        chk("rst_valid", {31'd0, oTX_VALID}, 0);
        chk("rst_data",  {14'd0, oTX_DATA}, 0);
        chk("rst_busy",  {31'd0, oBUSY}, 0);
        iRESET = 1'b0;
        cycles(2);

        // Basic 3-word frame
        word(1, 16'hF5F5); word(0, 16'h0003);
        word(0, 16'h0001); word(0, 16'h0002); word(0, 16'h0003); word(0, 16'h0006);
        exp_q.push_back(18'h2_0001); exp_q.push_back(18'h0_0002); exp_q.push_back(18'h1_0003);
        e_ok++;
        drain(0);
        check_counts("basic");

        // Bad checksum, then single-word frame
        word(1, 16'hF5F5); word(0, 16'h0003);
        word(0, 16'h0001); word(0, 16'h0002); word(0, 16'h0003); word(0, 16'h0007);
        e_csum++;
        word(1, 16'hF5F5); word(0, 16'h0001); word(0, 16'hABCD); word(0, 16'hABCD);
        exp_q.push_back(18'h3_ABCD);
        e_ok++;
        drain(0);
        check_counts("csum");

        // Length and sync errors; START=0 word in IDLE ignored
        word(0, 16'hF5F5);
        word(1, 16'hF5F5); word(0, 16'h0000); e_len++;
        word(1, 16'hF5F5); word(0, 16'h0010); e_len++;
        word(1, 16'hF5F5); word(0, 16'h0100); e_len++;
        word(1, 16'h1234); e_sync++;
        check_counts("errs");
        chk("idle_busy", {31'd0, oBUSY}, 0);

        // MAX_LEN frame: 1..15, sum 0x0078
        word(1, 16'hF5F5); word(0, 16'h000F);
        for (int i = 1; i <= 15; i++) word(0, 16'(i));
        word(0, 16'h0078);
        exp_q.push_back(18'h2_0001);
        for (int i = 2; i <= 14; i++) exp_q.push_back({2'b00, 16'(i)});
        exp_q.push_back(18'h1_000F);
        e_ok++;
        drain(0);
        check_counts("maxlen");

        // Resync mid-payload, with ENA gaps
        word(1, 16'hF5F5); word(0, 16'h0005); word(0, 16'h0011);
        gap(3);
        word(0, 16'h0022);
        chk("busy_payload", {31'd0, oBUSY}, 1);
        word(1, 16'hF5F5); e_len++;
        word(0, 16'h0002); gap(2); word(0, 16'hAAAA); word(0, 16'h5555); word(0, 16'hFFFF);
        exp_q.push_back(18'h2_AAAA); exp_q.push_back(18'h1_5555);
        e_ok++;
        drain(0);
        check_counts("resync");

        // Overflow with reader stalled: 0x100..0x109, sum 0x0A2D
        iTX_READY = 1'b0;
        word(1, 16'hF5F5); word(0, 16'h000A);
        for (int i = 0; i < 10; i++) word(0, 16'h0100 + 16'(i));
        word(0, 16'h0A2D);
        exp_q.push_back(18'h2_0100);
        for (int i = 1; i < 9; i++) exp_q.push_back({2'b00, 16'h0100 + 16'(i)});
        exp_q.push_back(18'h1_0109);
        e_ok++;
        word(1, 16'hF5F5); word(0, 16'h0008); e_ovf++;
        check_counts("ovf");
        drain(1);
        check_counts("ovf_drain");

        // Reset mid-payload with a committed word pending
        iTX_READY = 1'b0;
        word(1, 16'hF5F5); word(0, 16'h0001); word(0, 16'h7777); word(0, 16'h7777);
        exp_q.push_back(18'h3_7777);
        e_ok++;
        cycles(3);
        chk("pending_valid", {31'd0, oTX_VALID}, 1);
        word(1, 16'hF5F5); word(0, 16'h0003); word(0, 16'h0001); word(0, 16'h0002);
        iRESET = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        chk("rst2_valid", {31'd0, oTX_VALID}, 0);
        chk("rst2_data",  {14'd0, oTX_DATA}, 0);
        chk("rst2_busy",  {31'd0, oBUSY}, 0);
        chk("rst2_pulses", {27'd0, oFRAME_OK, oERR_SYNC, oERR_LEN, oERR_CSUM, oERR_OVF}, 0);
        @(posedge iCLK); #1;
        iRESET = 1'b0;
        exp_q.delete();
        iTX_READY = 1'b1;
        cycles(20);
        check_counts("reset");

        // Recovery after reset
        word(1, 16'hF5F5); word(0, 16'h0001); word(0, 16'h0042); word(0, 16'h0042);
        exp_q.push_back(18'h3_0042);
        e_ok++;
        drain(0);
        check_counts("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
